fifo: RTL and testbench



---
 rtl/fifo.sv | 83 ++++++++
 tb/tb_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Single-clock show-ahead FIFO with binary wrap-bit pointers, occupancy count and threshold flags.
// Define FIFO_ERR_FLAGS_EN to get sticky overflow/underflow flags; otherwise those ports read 0.
module fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_LVL  = (2**ADDR_WIDTH) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int                DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0]   r_wptr, r_rptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_empty, w_full, w_wr_acc, w_rd_acc;
    logic [ADDR_WIDTH:0]   w_count;

    // Extra MSB on each pointer distinguishes full from empty when the index bits match.
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                      (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
    assign w_count  = r_wptr - r_rptr;
    assign w_wr_acc = winc && !w_full;
    assign w_rd_acc = rinc && !w_empty;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
            if (w_rd_acc) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage is intentionally not reset; pointer reset alone discards contents.
    always_ff @(posedge wclk) begin
        if (w_wr_acc) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= wdata;
    end

    assign rdata        = r_mem[r_rptr[ADDR_WIDTH-1:0]];
    assign rempty       = w_empty;
    assign wfull        = w_full;
    assign count        = w_count;
    assign almost_full  = (w_count >= AFULL_C);
    assign almost_empty = (w_count <= AEMPTY_C);

`ifdef FIFO_ERR_FLAGS_EN
    logic r_ovf, r_udf;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (winc && w_full)  r_ovf <= 1'b1;
            if (rinc && w_empty) r_udf <= 1'b1;
        end
    end

    assign overflow  = r_ovf;
    assign underflow = r_udf;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: reset, show-ahead order, full/empty boundaries, simultaneous ops, async reset.
module tb_fifo;
    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic        winc = 1'b0;
    logic [63:0] wdata = '0;
    logic        wfull;
    logic        rinc = 1'b0;
    logic [63:0] rdata;
    logic        rempty;
    logic [4:0]  count;
    logic        almost_full, almost_empty, overflow, underflow;

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] q[$];
    logic ovf_exp = 1'b0;
    logic udf_exp = 1'b0;

    fifo dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wdata(wdata), .wfull(wfull),
        .rinc(rinc), .rdata(rdata), .rempty(rempty), .count(count),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given requests; reference queue tracks accepted operations.
    task automatic cyc(input logic w, input logic [63:0] d, input logic r);
        bit acc_w, acc_r;
        winc = w; wdata = d; rinc = r;
        acc_w = w && (q.size() != 16);
        acc_r = r && (q.size() != 0);
`ifdef FIFO_ERR_FLAGS_EN
        if (w && q.size() == 16) ovf_exp = 1'b1;
        if (r && q.size() == 0)  udf_exp = 1'b1;
`endif
        @(posedge wclk);
        if (acc_r) void'(q.pop_front());
        if (acc_w) q.push_back(d);
        #1;
        winc = 1'b0; rinc = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".rempty"}, 64'(rempty), 64'(q.size() == 0));
        chk({tag, ".wfull"}, 64'(wfull), 64'(q.size() == 16));
        if (q.size() != 0) chk({tag, ".rdata"}, rdata, q[0]);
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        q.delete();
        ovf_exp = 1'b0; udf_exp = 1'b0;
        #20;
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    initial begin
        // Reset held 20 ns
        #20;
        chk("rst.rempty", 64'(rempty), 64'd1);
        chk("rst.wfull", 64'(wfull), 64'd0);
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.aempty", 64'(almost_empty), 64'd1);
        chk("rst.afull", 64'(almost_full), 64'd0);
        chk("rst.ovf", 64'(overflow), 64'd0);
        chk("rst.udf", 64'(underflow), 64'd0);
        @(negedge wclk);
        wrst_n = 1'b1;

        // Four writes, show-ahead head
        cyc(1, 64'hAAAA_BBBB_CCCC_DDDD, 0);
        chk("w1.rdata", rdata, 64'hAAAA_BBBB_CCCC_DDDD);
        cyc(1, 64'h1111_2222_3333_4444, 0);
        cyc(1, 64'h5555_6666_7777_8888, 0);
        cyc(1, 64'h9999_AAAA_BBBB_CCCC, 0);
        chk("w4.count", 64'(count), 64'd4);
        chk("w4.rempty", 64'(rempty), 64'd0);
        chk("w4.rdata", rdata, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("w4.aempty", 64'(almost_empty), 64'd0);
        cyc(0, 0, 1);
        chk("r1.count", 64'(count), 64'd3);
        chk("r1.rdata", rdata, 64'h1111_2222_3333_4444);
        cyc(0, 0, 1);
        chk("r2.aempty", 64'(almost_empty), 64'd1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("r4.rempty", 64'(rempty), 64'd1);
        chk("r4.count", 64'(count), 64'd0);
        // Read while empty: no pointer movement
        cyc(0, 0, 1);
        chk("udf.count", 64'(count), 64'd0);
        chk("udf.rempty", 64'(rempty), 64'd1);
        chk("udf.flag", 64'(underflow), 64'(udf_exp));

        // Fill with 0..15 checking threshold boundaries
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1, 64'(i), 0);
            if (i == 1)  chk("f2.aempty", 64'(almost_empty), 64'd1);
            if (i == 2)  chk("f3.aempty", 64'(almost_empty), 64'd0);
            if (i == 12) chk("f13.afull", 64'(almost_full), 64'd0);
            if (i == 13) chk("f14.afull", 64'(almost_full), 64'd1);
        end
        chk("f16.wfull", 64'(wfull), 64'd1);
        chk("f16.afull", 64'(almost_full), 64'd1);
        chk("f16.count", 64'(count), 64'd16);
        cyc(1, 64'hDEAD, 0);
        chk("ovf.count", 64'(count), 64'd16);
        chk("ovf.rdata", rdata, 64'd0);
        chk("ovf.flag", 64'(overflow), 64'(ovf_exp));
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), rdata, 64'(i));
            cyc(0, 0, 1);
        end
        chk("drain.rempty", 64'(rempty), 64'd1);

        // Full with both requests: read wins, write dropped
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 64'(100 + i), 0);
        cyc(1, 64'd200, 1);
        chk("fb.count", 64'(count), 64'd15);
        chk("fb.rdata", rdata, 64'd101);
        chk("fb.wfull", 64'(wfull), 64'd0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1);
        chk("c8.count", 64'(count), 64'd8);
        chk("c8.rdata", rdata, 64'd108);
        // Steady state at 8 across pointer wrap
        for (int i = 0; i < 20; i++) begin
            cyc(1, 64'(300 + i), 1);
            chk_state($sformatf("ss%0d", i));
        end
        chk("ss.head", rdata, 64'd312);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ssd%0d", i), rdata, 64'(312 + i));
            cyc(0, 0, 1);
        end
        // Empty with both requests: write accepted, read ignored
        cyc(1, 64'h55, 1);
        chk("eb.count", 64'(count), 64'd1);
        chk("eb.rdata", rdata, 64'h55);
        chk("eb.udf", 64'(underflow), 64'(udf_exp));

        // Asynchronous reset mid-stream at count 5
        for (int i = 0; i < 4; i++) cyc(1, 64'(500 + i), 0);
        chk("mid.count", 64'(count), 64'd5);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.rempty", 64'(rempty), 64'd1);
        chk("arst.wfull", 64'(wfull), 64'd0);
        chk("arst.aempty", 64'(almost_empty), 64'd1);
        chk("arst.afull", 64'(almost_full), 64'd0);
        chk("arst.ovf", 64'(overflow), 64'd0);
        chk("arst.udf", 64'(underflow), 64'd0);
        do_reset();
        cyc(1, 64'h77, 0);
        chk("post.count", 64'(count), 64'd1);
        chk("post.rdata", rdata, 64'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
